countup_timer: RTL and testbench

- BCD elapsed-time and score up-counter. It is the count-up counterpart of the game's countdown timer.
- It has its own one-second prescaler with a turbo mode, a run/pause/done state machine, and saturation at a programmable BCD ceiling.
- Count_out uses the same packed 3-digit BCD format as the countdown, so the existing digit renderer can draw it unchanged.

---
 rtl/countup_pkg.sv | 39 +++
 rtl/countup_prescaler.sv | 45 ++++
 rtl/countup_timer.sv | 115 +++++++++++
 tb/tb_countup_timer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countup_pkg.sv
// Shared types and helpers for the BCD count-up timer.
//   state_t  : run/pause/done state machine encoding
//   BCD_W    : width of the packed 3-digit BCD count
//   bcd_inc  : packed 3-digit BCD increment with digit ripple
package countup_pkg;

  localparam int BCD_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_t;

  // Units 9->0 carries into tens, tens 9->0 carries into hundreds.
  // 999 would roll to 000, but the caller never increments at the ceiling.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [3:0] u;
    logic [3:0] t;
    logic [3:0] h;
    u = v[3:0];
    t = v[7:4];
    h = v[11:8];
    if (u == 4'd9) begin
      u = '0;
      if (t == 4'd9) begin
        t = '0;
        h = (h == 4'd9) ? 4'd0 : h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {h, t, u};
  endfunction

endpackage

// File: rtl/countup_prescaler.sv
// One-second (or turbo) prescaler for the count-up timer.
// Ports:
//   clk, resetN : system clock, synchronous active-low reset
//   hold        : freeze the counter (mid-period value is kept)
//   clr         : force the counter to zero
//   turbo       : select the short period CLK_HZ/TURBO_DIV
//   due         : high in the terminal cycle while counting; the consumer
//                 registers the increment on the following edge
module countup_prescaler #(
  parameter int CLK_HZ    = 31500000,
  parameter int TURBO_DIV = 10
) (
  input  logic clk,
  input  logic resetN,
  input  logic hold,
  input  logic clr,
  input  logic turbo,
  output logic due
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] TERM_NORM = W'(CLK_HZ - 1);
  localparam logic [W-1:0] TERM_FAST = W'(CLK_HZ / TURBO_DIV - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] term;

  // >= rather than == so that switching to turbo past the short terminal
  // value still produces an increment on the next edge.
  always_comb begin
    term = turbo ? TERM_FAST : TERM_NORM;
    due  = !hold && !clr && (cnt >= term);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= due ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/countup_timer.sv
// BCD elapsed-time / score up-counter with run/pause/done control and a
// programmable BCD ceiling.
// Ports:
//   clk, resetN  : system clock, synchronous active-low reset
//   start        : pulse, begin (from IDLE) or resume (from PAUSED)
//   stop         : pulse, pause while running
//   clear        : pulse, zero the count and return to IDLE (highest priority)
//   turbo        : level, selects the fast tick period
//   Count_out    : packed BCD {hundreds, tens, units}
//   running      : high in RUN
//   tick         : one-cycle pulse with each new Count_out value
//   limitReached : high in DONE
module countup_timer
  import countup_pkg::*;
#(
  parameter int          CLK_HZ    = 31500000,
  parameter int          TURBO_DIV = 10,
  parameter logic [11:0] MAX_BCD   = 12'h999
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        turbo,
  output logic [11:0] Count_out,
  output logic        running,
  output logic        tick,
  output logic        limitReached
);

  state_t           state;
  logic             pre_hold;
  logic             pre_clr;
  logic             due;
  logic [BCD_W-1:0] next_count;

  // Prescaler advances only in RUN cycles that are not being paused or
  // cleared, and sits at zero throughout IDLE so IDLE->RUN starts a full period.
  always_comb begin
    pre_hold   = (state != RUN) || stop;
    pre_clr    = clear || (state == IDLE);
    next_count = bcd_inc(Count_out);
  end

  countup_prescaler #(
    .CLK_HZ   (CLK_HZ),
    .TURBO_DIV(TURBO_DIV)
  ) u_prescaler (
    .clk   (clk),
    .resetN(resetN),
    .hold  (pre_hold),
    .clr   (pre_clr),
    .turbo (turbo),
    .due   (due)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= IDLE;
      Count_out    <= '0;
      running      <= 1'b0;
      tick         <= 1'b0;
      limitReached <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear) begin
        state        <= IDLE;
        Count_out    <= '0;
        running      <= 1'b0;
        limitReached <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (MAX_BCD == '0) begin
                state        <= DONE;
                limitReached <= 1'b1;
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (due && (Count_out < MAX_BCD)) begin
              Count_out <= next_count;
              tick      <= 1'b1;
              if (next_count == MAX_BCD) begin
                state        <= DONE;
                running      <= 1'b0;
                limitReached <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countup_timer.sv
module tb_countup_timer;

  localparam int          CLK_HZ    = 20;
  localparam int          TURBO_DIV = 4;
  localparam logic [11:0] MAX_BCD   = 12'h012;

  logic        clk;
  logic        resetN;
  logic        start;
  logic        stop;
  logic        clear;
  logic        turbo;
  logic [11:0] Count_out;
  logic        running;
  logic        tick;
  logic        limitReached;

  logic [11:0] z_count;
  logic        z_running;
  logic        z_tick;
  logic        z_limit;

  int checks   = 0;
  int failures = 0;

  countup_timer #(
    .CLK_HZ   (CLK_HZ),
    .TURBO_DIV(TURBO_DIV),
    .MAX_BCD  (MAX_BCD)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .turbo       (turbo),
    .Count_out   (Count_out),
    .running     (running),
    .tick        (tick),
    .limitReached(limitReached)
  );

  countup_timer #(
    .CLK_HZ   (CLK_HZ),
    .TURBO_DIV(TURBO_DIV),
    .MAX_BCD  (12'h000)
  ) dut_zero (
    .clk         (clk),
    .resetN      (resetN),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .turbo       (turbo),
    .Count_out   (z_count),
    .running     (z_running),
    .tick        (z_tick),
    .limitReached(z_limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: decimal count, elapsed cycles in the current period.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_mode = M_IDLE;
  int m_val  = 0;
  int m_el   = 0;
  bit m_tick = 1'b0;
  int max_dec;
  bit chk_en = 1'b0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin : model
    int mode;
    int val;
    int el;
    int period;
    bit tk;
    mode = m_mode;
    val  = m_val;
    el   = m_el;
    tk   = 1'b0;
    period = turbo ? CLK_HZ / TURBO_DIV : CLK_HZ;
    if (!resetN || clear) begin
      mode = M_IDLE;
      val  = 0;
      el   = 0;
    end else if (mode == M_IDLE) begin
      if (start) begin
        el   = 0;
        mode = (max_dec == 0) ? M_DONE : M_RUN;
      end
    end else if (mode == M_RUN) begin
      if (stop) begin
        mode = M_PAUSED;
      end else if (el + 1 >= period) begin
        el  = 0;
        val = val + 1;
        tk  = 1'b1;
        if (val == max_dec) mode = M_DONE;
      end else begin
        el = el + 1;
      end
    end else if (mode == M_PAUSED) begin
      if (start) mode = M_RUN;
    end
    m_mode <= mode;
    m_val  <= val;
    m_el   <= el;
    m_tick <= tk;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", Count_out, to_bcd(m_val));
      chk("model_running", {11'd0, running}, {11'd0, m_mode == M_RUN});
      chk("model_limit", {11'd0, limitReached}, {11'd0, m_mode == M_DONE});
      chk("model_tick", {11'd0, tick}, {11'd0, m_tick});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    logic [11:0] mx;
    mx      = MAX_BCD;
    max_dec = int'(mx[11:8]) * 100 + int'(mx[7:4]) * 10 + int'(mx[3:0]);
    resetN = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    clear  = 1'b0;
    turbo  = 1'b0;
    wait_cyc(3);
    chk_en = 1'b1;
    chk("reset_count", Count_out, 12'h000);
    chk("reset_flags", {9'd0, running, tick, limitReached}, 12'h000);
    chk("reset_zero_inst", {z_count[8:0], z_running, z_tick, z_limit}, 12'h000);
    resetN = 1'b1;
    wait_cyc(2);

    // Basic count, carry and saturation
    start_pulse();
    chk("zero_max_done", {9'd0, z_running, z_tick, z_limit}, 12'h001);
    chk("zero_max_count", z_count, 12'h000);
    wait_cyc(19);
    chk("basic_pre_first", Count_out, 12'h000);
    wait_cyc(1);
    chk("basic_first", Count_out, 12'h001);
    chk("basic_first_tick", {11'd0, tick}, 12'h001);
    wait_cyc(1);
    chk("basic_tick_width", {11'd0, tick}, 12'h000);
    wait_cyc(19);
    chk("basic_second", Count_out, 12'h002);
    wait_cyc(160);
    chk("carry_010", Count_out, 12'h010);
    wait_cyc(40);
    chk("sat_count", Count_out, 12'h012);
    chk("sat_flags", {10'd0, running, limitReached}, 12'h001);
    wait_cyc(100);
    start_pulse();
    wait_cyc(5);
    chk("sat_hold", Count_out, 12'h012);
    chk("sat_start_ignored", {10'd0, running, limitReached}, 12'h001);
    clear_pulse();
    chk("clear_count", Count_out, 12'h000);
    chk("clear_flags", {10'd0, running, limitReached}, 12'h000);

    // Turbo from the start
    turbo = 1'b1;
    start_pulse();
    wait_cyc(4);
    chk("turbo_pre", Count_out, 12'h000);
    wait_cyc(1);
    chk("turbo_first", Count_out, 12'h001);
    wait_cyc(5);
    chk("turbo_second", Count_out, 12'h002);
    turbo = 1'b0;
    clear_pulse();

    // Turbo asserted mid-period at prescaler 12
    start_pulse();
    wait_cyc(12);
    turbo = 1'b1;
    wait_cyc(1);
    chk("turbo_mid_first", Count_out, 12'h001);
    wait_cyc(5);
    chk("turbo_mid_second", Count_out, 12'h002);
    turbo = 1'b0;
    clear_pulse();

    // Pause at prescaler 7, resume
    start_pulse();
    wait_cyc(7);
    stop_pulse();
    chk("pause_running", {11'd0, running}, 12'h000);
    wait_cyc(50);
    chk("pause_frozen", Count_out, 12'h000);
    start_pulse();
    wait_cyc(12);
    chk("resume_pre", Count_out, 12'h000);
    wait_cyc(1);
    chk("resume_tick", {Count_out[10:0], tick}, {11'h001, 1'b1});

    // Priority
    clear = 1'b1;
    stop  = 1'b1;
    start = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    stop  = 1'b0;
    start = 1'b0;
    chk("prio_all_count", Count_out, 12'h000);
    chk("prio_all_running", {11'd0, running}, 12'h000);
    start_pulse();
    wait_cyc(3);
    stop  = 1'b1;
    start = 1'b1;
    wait_cyc(1);
    stop  = 1'b0;
    start = 1'b0;
    chk("prio_stop_start", {11'd0, running}, 12'h000);
    start_pulse();
    chk("prio_resume", {11'd0, running}, 12'h001);
    clear_pulse();

    // Stop in the terminal cycle
    start_pulse();
    wait_cyc(19);
    stop_pulse();
    chk("term_stop_count", {Count_out[10:0], tick}, 12'h000);
    wait_cyc(5);
    start_pulse();
    wait_cyc(1);
    chk("term_stop_resume", {Count_out[10:0], tick}, {11'h001, 1'b1});
    clear_pulse();

    // Clear in the terminal cycle
    start_pulse();
    wait_cyc(19);
    clear_pulse();
    chk("term_clear", {Count_out[10:0], tick}, 12'h000);

    // Reset mid-run at 007
    start_pulse();
    wait_cyc(140);
    chk("mid_run_007", Count_out, 12'h007);
    resetN = 1'b0;
    wait_cyc(1);
    resetN = 1'b1;
    chk("rst_mid_count", Count_out, 12'h000);
    chk("rst_mid_flags", {9'd0, running, tick, limitReached}, 12'h000);
    start_pulse();
    wait_cyc(19);
    chk("rst_full_period", Count_out, 12'h000);
    wait_cyc(1);
    chk("rst_first", Count_out, 12'h001);
    wait_cyc(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
